// File: rtl/spu_odd_pkg.sv
// Shared types and default latencies for the SPU odd pipe (issue control,
// permute and local-store blocks).
package spu_odd_pkg;

  typedef enum logic [1:0] {
    UNIT_PERM = 2'd0,
    UNIT_LS   = 2'd1,
    UNIT_BR   = 2'd2,
    UNIT_NOP  = 2'd3
  } unit_sel_e;

  localparam int DEF_PERM_LAT = 4;
  localparam int DEF_LS_LAT   = 6;
  localparam int DEF_BR_LAT   = 1;
  localparam int MAX_LAT      = 7;

  localparam int ADDR_W   = 7;
  localparam int SB_DEPTH = MAX_LAT + 1;
  localparam int REM_W    = $clog2(MAX_LAT + 1);
  localparam int IDX_W    = $clog2(SB_DEPTH);
  localparam int CNT_W    = 3;

  // remaining = cycles until writeback plus one; the entry is live through
  // its writeback cycle and frees on the following edge.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rt;
    logic [REM_W-1:0]  rem;
  } sb_entry_t;

endpackage

// File: rtl/odd_scoreboard.sv
// In-flight destination scoreboard for the odd pipe: entry storage,
// per-cycle countdown/retire, and RAW/WAW match outputs.
module odd_scoreboard
  import spu_odd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_rt,
  input  logic [REM_W-1:0]  alloc_rem,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic              ra_used,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              rb_used,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [REM_W-1:0]  waw_thresh,
  output logic              raw_hit,
  output logic              waw_hit,
  output logic [CNT_W-1:0]  inflight_cnt
);

  sb_entry_t           sb_q [SB_DEPTH];
  sb_entry_t           sb_d [SB_DEPTH];
  logic [SB_DEPTH-1:0] slot_free;
  logic [IDX_W-1:0]    alloc_idx;
  logic                alloc_ok;
  logic [IDX_W:0]      valid_sum;

  // A retiring slot counts as free so a same-cycle allocation can reuse it.
  always_comb begin
    slot_free = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot_free[i] = !sb_q[i].valid || (sb_q[i].rem == REM_W'(1));
    end
  end

  always_comb begin
    alloc_idx = '0;
    alloc_ok  = 1'b0;
    for (int i = SB_DEPTH - 1; i >= 0; i--) begin
      if (slot_free[i]) begin
        alloc_idx = IDX_W'(i);
        alloc_ok  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SB_DEPTH; i++) begin
      sb_d[i] = sb_q[i];
      if (sb_q[i].valid) begin
        if (sb_q[i].rem == REM_W'(1)) begin
          sb_d[i] = '0;
        end else begin
          sb_d[i].rem = sb_q[i].rem - REM_W'(1);
        end
      end
    end
    if (alloc && alloc_ok) begin
      sb_d[alloc_idx].valid = 1'b1;
      sb_d[alloc_idx].rt    = alloc_rt;
      sb_d[alloc_idx].rem   = alloc_rem;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_q[i] <= sb_d[i];
      end
    end
  end

  always_comb begin
    raw_hit   = 1'b0;
    waw_hit   = 1'b0;
    valid_sum = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_q[i].valid) begin
        if ((ra_used && (ra_addr == sb_q[i].rt)) ||
            (rb_used && (rb_addr == sb_q[i].rt))) begin
          raw_hit = 1'b1;
        end
        if ((rt_addr == sb_q[i].rt) && (sb_q[i].rem > waw_thresh)) begin
          waw_hit = 1'b1;
        end
      end
      valid_sum = valid_sum + (IDX_W + 1)'(sb_q[i].valid);
    end
  end

  assign inflight_cnt = (valid_sum > (IDX_W + 1)'(7)) ? CNT_W'(7) : valid_sum[CNT_W-1:0];

endmodule

// File: rtl/odd_pipe_issue_ctrl.sv
// Odd-pipe issue scheduler: hazard/writeback-port stall logic and issue strobes.
// Optional stall-cause counters are built when ODD_ISSUE_PERF_EN is defined.
module odd_pipe_issue_ctrl
  import spu_odd_pkg::*;
#(
  parameter int PERM_LAT = DEF_PERM_LAT,
  parameter int LS_LAT   = DEF_LS_LAT,
  parameter int BR_LAT   = DEF_BR_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        unit_sel,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              ra_used,
  input  logic              rb_used,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              reg_write,
  output logic              issue_perm,
  output logic              issue_ls,
  output logic              issue_br,
  output logic [ADDR_W-1:0] issue_rt_addr,
  output logic              issue_reg_write,
  output logic              wb_expect,
  output logic [CNT_W-1:0]  inflight_cnt
`ifdef ODD_ISSUE_PERF_EN
  ,
  output logic [31:0]       stall_struct_cnt,
  output logic [31:0]       stall_raw_cnt,
  output logic [31:0]       stall_waw_cnt
`endif
);

  // Handshake: an instruction transfers on a cycle with in_valid && in_ready;
  // in_ready is purely a function of hazards on the presented fields (never
  // of in_valid), and a stalled producer must hold its fields stable.

  unit_sel_e          usel;
  logic [REM_W-1:0]   lat;
  logic [REM_W-1:0]   lat_p1;
  logic               writes;
  logic               raw_hit;
  logic               waw_hit;
  logic               waw_stall;
  logic               struct_hit;
  logic               accept;
  logic               alloc;
  logic [MAX_LAT:0]   wb_res_q;
  logic [MAX_LAT:0]   wb_res_d;

  assign usel = unit_sel_e'(unit_sel);

  always_comb begin
    lat = '0;
    case (usel)
      UNIT_PERM: lat = REM_W'(PERM_LAT);
      UNIT_LS:   lat = REM_W'(LS_LAT);
      UNIT_BR:   lat = REM_W'(BR_LAT);
      default:   lat = '0;
    endcase
  end

  assign lat_p1 = lat + REM_W'(1);

  // Nops and non-writing instructions never touch the port or the scoreboard.
  assign writes = reg_write && (usel != UNIT_NOP);

  // wb_res_q[k] = port busy k cycles from now; writeback lands at now+1+L.
  assign struct_hit = writes && wb_res_q[lat_p1];
  assign waw_stall  = writes && waw_hit;
  assign in_ready   = !reset && !(raw_hit || waw_stall || struct_hit);
  assign accept     = in_valid && in_ready;
  assign alloc      = accept && writes;

  assign wb_res_d = {1'b0, wb_res_q[MAX_LAT:1]} |
                    (alloc ? ((MAX_LAT + 1)'(1) << lat) : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_res_q <= '0;
    end else begin
      wb_res_q <= wb_res_d;
    end
  end

  assign wb_expect = wb_res_q[0];

  odd_scoreboard u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .alloc        (alloc),
    .alloc_rt     (rt_addr),
    .alloc_rem    (lat_p1),
    .ra_addr      (ra_addr),
    .ra_used      (ra_used),
    .rb_addr      (rb_addr),
    .rb_used      (rb_used),
    .rt_addr      (rt_addr),
    .waw_thresh   (lat_p1),
    .raw_hit      (raw_hit),
    .waw_hit      (waw_hit),
    .inflight_cnt (inflight_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_perm      <= 1'b0;
      issue_ls        <= 1'b0;
      issue_br        <= 1'b0;
      issue_rt_addr   <= '0;
      issue_reg_write <= 1'b0;
    end else begin
      issue_perm      <= accept && (usel == UNIT_PERM);
      issue_ls        <= accept && (usel == UNIT_LS);
      issue_br        <= accept && (usel == UNIT_BR);
      issue_rt_addr   <= (accept && (usel != UNIT_NOP)) ? rt_addr : '0;
      issue_reg_write <= accept && (usel != UNIT_NOP) && reg_write;
    end
  end

`ifdef ODD_ISSUE_PERF_EN
  // One cause per stalled cycle, attributed RAW first, then WAW, then port.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_struct_cnt <= '0;
      stall_raw_cnt    <= '0;
      stall_waw_cnt    <= '0;
    end else if (in_valid && !in_ready) begin
      if (raw_hit) begin
        if (stall_raw_cnt != '1) stall_raw_cnt <= stall_raw_cnt + 32'd1;
      end else if (waw_stall) begin
        if (stall_waw_cnt != '1) stall_waw_cnt <= stall_waw_cnt + 32'd1;
      end else if (struct_hit) begin
        if (stall_struct_cnt != '1) stall_struct_cnt <= stall_struct_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_odd_pipe_issue_ctrl.sv
// Directed bench for odd_pipe_issue_ctrl: reset, issue timing, port
// collisions, RAW/WAW stalls, nops and reset while busy.
module tb_odd_pipe_issue_ctrl;

  localparam logic [1:0] U_PERM = 2'd0;
  localparam logic [1:0] U_LS   = 2'd1;
  localparam logic [1:0] U_BR   = 2'd2;
  localparam logic [1:0] U_NOP  = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] unit_sel;
  logic [6:0] ra_addr;
  logic [6:0] rb_addr;
  logic       ra_used;
  logic       rb_used;
  logic [6:0] rt_addr;
  logic       reg_write;
  logic       issue_perm;
  logic       issue_ls;
  logic       issue_br;
  logic [6:0] issue_rt_addr;
  logic       issue_reg_write;
  logic       wb_expect;
  logic [2:0] inflight_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  odd_pipe_issue_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .unit_sel        (unit_sel),
    .ra_addr         (ra_addr),
    .rb_addr         (rb_addr),
    .ra_used         (ra_used),
    .rb_used         (rb_used),
    .rt_addr         (rt_addr),
    .reg_write       (reg_write),
    .issue_perm      (issue_perm),
    .issue_ls        (issue_ls),
    .issue_br        (issue_br),
    .issue_rt_addr   (issue_rt_addr),
    .issue_reg_write (issue_reg_write),
    .wb_expect       (wb_expect),
    .inflight_cnt    (inflight_cnt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_in(input logic v, input logic [1:0] u, input logic [6:0] ra,
                        input logic rau, input logic [6:0] rb, input logic rbu,
                        input logic [6:0] rt, input logic rw);
    in_valid  = v;
    unit_sel  = u;
    ra_addr   = ra;
    ra_used   = rau;
    rb_addr   = rb;
    rb_used   = rbu;
    rt_addr   = rt;
    reg_write = rw;
  endtask

  task automatic idle();
    set_in(1'b0, U_NOP, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (3) next_cyc();
    reset = 1'b0;
    mid();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if ({issue_perm, issue_ls, issue_br} !== 3'b000) begin bad++; $display("FAIL rst_issue got=%b exp=000", {issue_perm, issue_ls, issue_br}); end
    total++; if (issue_rt_addr !== 7'd0) begin bad++; $display("FAIL rst_issue_rt got=%0d exp=0", issue_rt_addr); end
    total++; if (issue_reg_write !== 1'b0) begin bad++; $display("FAIL rst_issue_rw got=%b exp=0", issue_reg_write); end
    total++; if (wb_expect !== 1'b0) begin bad++; $display("FAIL rst_wb_expect got=%b exp=0", wb_expect); end
    total++; if (inflight_cnt !== 3'd0) begin bad++; $display("FAIL rst_inflight got=%0d exp=0", inflight_cnt); end
  endtask

  task automatic test_perm_basic();
    next_cyc();
    set_in(1'b1, U_PERM, 7'd0, 1'b0, 7'd0, 1'b0, 7'd5, 1'b1);
    mid();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL perm_accept got=%b exp=1", in_ready); end
    for (int j = 1; j <= 6; j++) begin
      next_cyc();
      idle();
      mid();
      total++; if (issue_perm !== (j == 1)) begin bad++; $display("FAIL perm_strobe t+%0d got=%b exp=%b", j, issue_perm, (j == 1)); end
      total++; if (wb_expect !== (j == 5)) begin bad++; $display("FAIL perm_wb t+%0d got=%b exp=%b", j, wb_expect, (j == 5)); end
      total++; if (inflight_cnt !== ((j <= 5) ? 3'd1 : 3'd0)) begin bad++; $display("FAIL perm_inflight t+%0d got=%0d exp=%0d", j, inflight_cnt, (j <= 5) ? 1 : 0); end
      if (j == 1) begin
        total++; if (issue_rt_addr !== 7'd5) begin bad++; $display("FAIL perm_rt got=%0d exp=5", issue_rt_addr); end
        total++; if (issue_reg_write !== 1'b1) begin bad++; $display("FAIL perm_rw got=%b exp=1", issue_reg_write); end
      end
    end
  endtask

  task automatic test_struct();
    next_cyc();
    set_in(1'b1, U_LS, 7'd0, 1'b0, 7'd0, 1'b0, 7'd3, 1'b1);
    mid();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ls_accept got=%b exp=1", in_ready); end
    next_cyc();
    idle();
    mid();
    total++; if (issue_ls !== 1'b1) begin bad++; $display("FAIL ls_strobe got=%b exp=1", issue_ls); end
    next_cyc();
    set_in(1'b1, U_PERM, 7'd0, 1'b0, 7'd0, 1'b0, 7'd4, 1'b1);
    mid();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL struct_stall got=%b exp=0", in_ready); end
    next_cyc();
    mid();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL struct_release got=%b exp=1", in_ready); end
    for (int j = 4; j <= 9; j++) begin
      next_cyc();
      idle();
      mid();
      if (j == 4) begin
        total++; if (issue_perm !== 1'b1) begin bad++; $display("FAIL struct_perm_strobe got=%b exp=1", issue_perm); end
      end
      total++; if (wb_expect !== (j == 7 || j == 8)) begin bad++; $display("FAIL struct_wb t+%0d got=%b exp=%b", j, wb_expect, (j == 7 || j == 8)); end
    end
    total++; if (inflight_cnt !== 3'd0) begin bad++; $display("FAIL struct_drain got=%0d exp=0", inflight_cnt); end
  endtask

  task automatic test_raw();
    next_cyc();
    set_in(1'b1, U_PERM, 7'd0, 1'b0, 7'd0, 1'b0, 7'd9, 1'b1);
    mid();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL raw_prod_accept got=%b exp=1", in_ready); end
    for (int j = 1; j <= 6; j++) begin
      next_cyc();
      set_in(1'b1, U_PERM, 7'd9, 1'b1, 7'd0, 1'b0, 7'd10, 1'b1);
      mid();
      total++; if (in_ready !== (j == 6)) begin bad++; $display("FAIL raw_ready t+%0d got=%b exp=%b", j, in_ready, (j == 6)); end
      if (j == 5) begin
        total++; if (wb_expect !== 1'b1) begin bad++; $display("FAIL raw_wb_cycle got=%b exp=1", wb_expect); end
      end
    end
    next_cyc();
    idle();
    mid();
    total++; if (issue_perm !== 1'b1) begin bad++; $display("FAIL raw_consumer_strobe got=%b exp=1", issue_perm); end
    total++; if (issue_rt_addr !== 7'd10) begin bad++; $display("FAIL raw_consumer_rt got=%0d exp=10", issue_rt_addr); end
    repeat (6) next_cyc();
  endtask

  task automatic test_waw();
    next_cyc();
    set_in(1'b1, U_LS, 7'd0, 1'b0, 7'd0, 1'b0, 7'd8, 1'b1);
    mid();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL waw_ls_accept got=%b exp=1", in_ready); end
    for (int j = 1; j <= 6; j++) begin
      next_cyc();
      set_in(1'b1, U_BR, 7'd0, 1'b0, 7'd0, 1'b0, 7'd8, 1'b1);
      mid();
      total++; if (in_ready !== (j == 6)) begin bad++; $display("FAIL waw_ready t+%0d got=%b exp=%b", j, in_ready, (j == 6)); end
    end
    for (int j = 7; j <= 9; j++) begin
      next_cyc();
      idle();
      mid();
      if (j == 7) begin
        total++; if (issue_br !== 1'b1) begin bad++; $display("FAIL waw_br_strobe got=%b exp=1", issue_br); end
      end
      total++; if (wb_expect !== (j == 7 || j == 8)) begin bad++; $display("FAIL waw_wb t+%0d got=%b exp=%b", j, wb_expect, (j == 7 || j == 8)); end
    end
    total++; if (inflight_cnt !== 3'd0) begin bad++; $display("FAIL waw_drain got=%0d exp=0", inflight_cnt); end
  endtask

  task automatic test_nop();
    next_cyc();
    set_in(1'b1, U_PERM, 7'd0, 1'b0, 7'd0, 1'b0, 7'd20, 1'b1);
    mid();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nop_prod_accept got=%b exp=1", in_ready); end
    next_cyc();
    set_in(1'b1, U_NOP, 7'd0, 1'b0, 7'd20, 1'b1, 7'd0, 1'b0);
    mid();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL nop_rb_raw got=%b exp=0", in_ready); end
    next_cyc();
    set_in(1'b1, U_NOP, 7'd0, 1'b0, 7'd0, 1'b0, 7'd20, 1'b1);
    mid();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nop_no_waw got=%b exp=1", in_ready); end
    next_cyc();
    set_in(1'b1, U_PERM, 7'd0, 1'b0, 7'd0, 1'b0, 7'd20, 1'b0);
    mid();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nowrite_accept got=%b exp=1", in_ready); end
    total++; if ({issue_perm, issue_ls, issue_br} !== 3'b000) begin bad++; $display("FAIL nop_no_strobe got=%b exp=000", {issue_perm, issue_ls, issue_br}); end
    total++; if (inflight_cnt !== 3'd1) begin bad++; $display("FAIL nop_no_entry got=%0d exp=1", inflight_cnt); end
    for (int j = 4; j <= 6; j++) begin
      next_cyc();
      idle();
      mid();
      if (j == 4) begin
        total++; if (issue_perm !== 1'b1) begin bad++; $display("FAIL nowrite_strobe got=%b exp=1", issue_perm); end
        total++; if (issue_reg_write !== 1'b0) begin bad++; $display("FAIL nowrite_rw got=%b exp=0", issue_reg_write); end
        total++; if (inflight_cnt !== 3'd1) begin bad++; $display("FAIL nowrite_no_entry got=%0d exp=1", inflight_cnt); end
      end
      total++; if (wb_expect !== (j == 5)) begin bad++; $display("FAIL nop_wb t+%0d got=%b exp=%b", j, wb_expect, (j == 5)); end
    end
    total++; if (inflight_cnt !== 3'd0) begin bad++; $display("FAIL nop_drain got=%0d exp=0", inflight_cnt); end
  endtask

  task automatic test_back_to_back();
    next_cyc();
    set_in(1'b1, U_LS, 7'd0, 1'b0, 7'd0, 1'b0, 7'd1, 1'b1);
    mid();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ls got=%b exp=1", in_ready); end
    next_cyc();
    set_in(1'b1, U_PERM, 7'd0, 1'b0, 7'd0, 1'b0, 7'd2, 1'b1);
    mid();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_perm got=%b exp=1", in_ready); end
    next_cyc();
    set_in(1'b1, U_BR, 7'd0, 1'b0, 7'd0, 1'b0, 7'd3, 1'b1);
    mid();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_br got=%b exp=1", in_ready); end
    for (int j = 3; j <= 8; j++) begin
      next_cyc();
      idle();
      mid();
      if (j == 3) begin
        total++; if (inflight_cnt !== 3'd3) begin bad++; $display("FAIL b2b_inflight3 got=%0d exp=3", inflight_cnt); end
        total++; if (issue_br !== 1'b1) begin bad++; $display("FAIL b2b_br_strobe got=%b exp=1", issue_br); end
      end
      if (j == 5) begin
        total++; if (inflight_cnt !== 3'd2) begin bad++; $display("FAIL b2b_inflight2 got=%0d exp=2", inflight_cnt); end
      end
      total++; if (wb_expect !== (j == 4 || j == 6 || j == 7)) begin bad++; $display("FAIL b2b_wb t+%0d got=%b exp=%b", j, wb_expect, (j == 4 || j == 6 || j == 7)); end
    end
    total++; if (inflight_cnt !== 3'd0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0", inflight_cnt); end
  endtask

  task automatic test_reset_mid();
    next_cyc();
    set_in(1'b1, U_LS, 7'd0, 1'b0, 7'd0, 1'b0, 7'd11, 1'b1);
    next_cyc();
    set_in(1'b1, U_PERM, 7'd0, 1'b0, 7'd0, 1'b0, 7'd12, 1'b1);
    next_cyc();
    set_in(1'b1, U_BR, 7'd0, 1'b0, 7'd0, 1'b0, 7'd13, 1'b1);
    next_cyc();
    idle();
    mid();
    total++; if (inflight_cnt !== 3'd3) begin bad++; $display("FAIL rmid_busy got=%0d exp=3", inflight_cnt); end
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    set_in(1'b1, U_PERM, 7'd11, 1'b1, 7'd13, 1'b1, 7'd14, 1'b1);
    mid();
    total++; if (inflight_cnt !== 3'd0) begin bad++; $display("FAIL rmid_inflight got=%0d exp=0", inflight_cnt); end
    total++; if (wb_expect !== 1'b0) begin bad++; $display("FAIL rmid_wb got=%b exp=0", wb_expect); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_dep_ready got=%b exp=1", in_ready); end
    next_cyc();
    idle();
    mid();
    total++; if (issue_perm !== 1'b1) begin bad++; $display("FAIL rmid_dep_strobe got=%b exp=1", issue_perm); end
    repeat (6) next_cyc();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_perm_basic();
    test_struct();
    test_raw();
    test_waw();
    test_nop();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
